// File: rtl/mips_seq_alu.sv
// Handshaked MIPS ALU: registered single-cycle ops, iterative shift-add MUL with HI word.
// Define SEQ_ALU_DIVIDER_EN to build the iterative restoring DIVU; otherwise op 011 yields 0.
module mips_seq_alu #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] scrA,
  input  logic [WIDTH-1:0] scrB,
  input  logic [2:0]       ALU_Control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALU_RESULT,
  output logic [WIDTH-1:0] ALU_RESULT_HI,
  output logic             zero_flag,
  output logic             ovf_flag,
  output logic             dbz_flag
);

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_DIVU = 3'b011;
  localparam logic [2:0] OP_SUB  = 3'b100;
  localparam logic [2:0] OP_MUL  = 3'b101;
  localparam logic [2:0] OP_SLTU = 3'b110;
  localparam logic [2:0] OP_NOR  = 3'b111;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MUL_BUSY = 2'd1,
`ifdef SEQ_ALU_DIVIDER_EN
    DIV_BUSY = 2'd2,
`endif
    DONE     = 2'd3
  } state_t;

  function automatic logic add_ovf(input logic signed [WIDTH-1:0] a,
                                   input logic signed [WIDTH-1:0] b,
                                   input logic signed [WIDTH-1:0] s);
    return (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
  endfunction

  function automatic logic sub_ovf(input logic signed [WIDTH-1:0] a,
                                   input logic signed [WIDTH-1:0] b,
                                   input logic signed [WIDTH-1:0] s);
    return (a[WIDTH-1] != b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
  endfunction

  state_t                  state, state_nxt;
  logic                    accept, op_iter, busy, last_step, vld_p1;
  logic signed [WIDTH-1:0] a_s, b_s, sum_s, dif_s;
  logic        [WIDTH-1:0] sc_res;
  logic                    sc_ovf;
  logic        [WIDTH-1:0] hi_p1, lo_p1, opd_p1;
  logic        [CNT_W-1:0] cnt_p1;
  logic        [WIDTH:0]   mul_sum;
  logic        [WIDTH-1:0] mul_hi_nxt, mul_lo_nxt;
`ifdef SEQ_ALU_DIVIDER_EN
  logic        [WIDTH:0]   div_shf, div_dif;
  logic                    div_ge;
  logic        [WIDTH-1:0] div_rem_nxt, div_q_nxt;
`endif

  assign vld_p1    = (state == DONE);
  assign out_valid = vld_p1;
  assign in_ready  = (state == IDLE) || (vld_p1 && out_ready);
  assign accept    = in_valid && in_ready;
  assign last_step = (cnt_p1 == CNT_W'(WIDTH - 1));

  always_comb begin
    op_iter = (ALU_Control == OP_MUL);
    busy    = (state == MUL_BUSY);
`ifdef SEQ_ALU_DIVIDER_EN
    if (ALU_Control == OP_DIVU) op_iter = 1'b1;
    if (state == DIV_BUSY) busy = 1'b1;
`endif
  end

  // Stage p0: single-cycle ops evaluated straight from the operand bus
  assign a_s   = $signed(scrA);
  assign b_s   = $signed(scrB);
  assign sum_s = a_s + b_s;
  assign dif_s = a_s - b_s;

  always_comb begin
    sc_res = '0;
    sc_ovf = 1'b0;
    case (ALU_Control)
      OP_AND:  sc_res = scrA & scrB;
      OP_OR:   sc_res = scrA | scrB;
      OP_ADD:  begin sc_res = $unsigned(sum_s); sc_ovf = add_ovf(a_s, b_s, sum_s); end
      OP_SUB:  begin sc_res = $unsigned(dif_s); sc_ovf = sub_ovf(a_s, b_s, dif_s); end
      OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, (scrA < scrB)};
      OP_NOR:  sc_res = ~(scrA | scrB);
      OP_DIVU: sc_res = '0;
      default: sc_res = '0;
    endcase
  end

  // Iteration step: MUL keeps {hi, lo} as the product shifter, DIVU keeps {rem, quotient}
  assign mul_sum    = {1'b0, hi_p1} + (lo_p1[0] ? {1'b0, opd_p1} : {(WIDTH+1){1'b0}});
  assign mul_hi_nxt = mul_sum[WIDTH:1];
  assign mul_lo_nxt = {mul_sum[0], lo_p1[WIDTH-1:1]};

`ifdef SEQ_ALU_DIVIDER_EN
  // A zero divisor always "fits", giving an all-ones quotient with the dividend left as remainder
  assign div_shf     = {hi_p1, lo_p1[WIDTH-1]};
  assign div_dif     = div_shf - {1'b0, opd_p1};
  assign div_ge      = ~div_dif[WIDTH];
  assign div_rem_nxt = div_ge ? div_dif[WIDTH-1:0] : div_shf[WIDTH-1:0];
  assign div_q_nxt   = {lo_p1[WIDTH-2:0], div_ge};
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (accept) begin
          if (ALU_Control == OP_MUL) state_nxt = MUL_BUSY;
`ifdef SEQ_ALU_DIVIDER_EN
          else if (ALU_Control == OP_DIVU) state_nxt = DIV_BUSY;
`endif
          else state_nxt = DONE;
        end else if (vld_p1 && out_ready) begin
          state_nxt = IDLE;
        end
      end
      MUL_BUSY: if (last_step) state_nxt = DONE;
`ifdef SEQ_ALU_DIVIDER_EN
      DIV_BUSY: if (last_step) state_nxt = DONE;
`endif
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)         cnt_p1 <= '0;
    else if (accept) cnt_p1 <= '0;
    else if (busy)   cnt_p1 <= cnt_p1 + 1'b1;
  end

  // Stage p1: iterative operand/partial registers
  always_ff @(posedge clk) begin
    if (accept) begin
      hi_p1 <= '0;
      if (ALU_Control == OP_MUL) begin
        lo_p1  <= scrB;
        opd_p1 <= scrA;
      end else begin
        lo_p1  <= scrA;
        opd_p1 <= scrB;
      end
    end else if (state == MUL_BUSY) begin
      hi_p1 <= mul_hi_nxt;
      lo_p1 <= mul_lo_nxt;
`ifdef SEQ_ALU_DIVIDER_EN
    end else if (state == DIV_BUSY) begin
      hi_p1 <= div_rem_nxt;
      lo_p1 <= div_q_nxt;
`endif
    end
  end

  // Stage p1 result registers: only written on entry to DONE, so they hold under backpressure
  always_ff @(posedge clk) begin
    if (rst) begin
      ALU_RESULT    <= '0;
      ALU_RESULT_HI <= '0;
      zero_flag     <= 1'b0;
      ovf_flag      <= 1'b0;
      dbz_flag      <= 1'b0;
    end else if (accept && !op_iter) begin
      ALU_RESULT    <= sc_res;
      ALU_RESULT_HI <= '0;
      zero_flag     <= (sc_res == '0);
      ovf_flag      <= sc_ovf;
      dbz_flag      <= 1'b0;
    end else if (state == MUL_BUSY && last_step) begin
      ALU_RESULT    <= mul_lo_nxt;
      ALU_RESULT_HI <= mul_hi_nxt;
      zero_flag     <= (mul_lo_nxt == '0);
      ovf_flag      <= 1'b0;
      dbz_flag      <= 1'b0;
`ifdef SEQ_ALU_DIVIDER_EN
    end else if (state == DIV_BUSY && last_step) begin
      ALU_RESULT    <= div_q_nxt;
      ALU_RESULT_HI <= div_rem_nxt;
      zero_flag     <= (div_q_nxt == '0);
      ovf_flag      <= 1'b0;
      dbz_flag      <= (opd_p1 == '0);
`endif
    end
  end

endmodule

// File: tb/tb_mips_seq_alu.sv
// Scoreboard bench for mips_seq_alu: a 32-bit instance driven through a queue-based checker
// and an 8-bit instance checked directly.
module tb_mips_seq_alu;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_DIVU = 3'b011;
  localparam logic [2:0] OP_SUB  = 3'b100;
  localparam logic [2:0] OP_MUL  = 3'b101;
  localparam logic [2:0] OP_SLTU = 3'b110;
  localparam logic [2:0] OP_NOR  = 3'b111;

  typedef struct {
    logic [31:0] res;
    logic [31:0] hi;
    logic        zero;
    logic        ovf;
    logic        dbz;
    int          lat;
    int          acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] scrA, scrB, ALU_RESULT, ALU_RESULT_HI;
  logic [2:0]  ALU_Control;
  logic        zero_flag, ovf_flag, dbz_flag;

  logic        w8_in_valid, w8_in_ready, w8_out_valid, w8_out_ready;
  logic [7:0]  w8_a, w8_b, w8_res, w8_hi;
  logic [2:0]  w8_ctl;
  logic        w8_zero, w8_ovf, w8_dbz;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  bit          seen = 1'b0;
  int          first_cyc = 0;
  logic [31:0] snap_res, snap_hi;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mips_seq_alu #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .scrA(scrA), .scrB(scrB), .ALU_Control(ALU_Control),
    .out_valid(out_valid), .out_ready(out_ready),
    .ALU_RESULT(ALU_RESULT), .ALU_RESULT_HI(ALU_RESULT_HI),
    .zero_flag(zero_flag), .ovf_flag(ovf_flag), .dbz_flag(dbz_flag)
  );

  mips_seq_alu #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(w8_in_valid), .in_ready(w8_in_ready),
    .scrA(w8_a), .scrB(w8_b), .ALU_Control(w8_ctl),
    .out_valid(w8_out_valid), .out_ready(w8_out_ready),
    .ALU_RESULT(w8_res), .ALU_RESULT_HI(w8_hi),
    .zero_flag(w8_zero), .ovf_flag(w8_ovf), .dbz_flag(w8_dbz)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    longint      sa, sbv, r;
    longint      lim_hi, lim_lo;
    logic [63:0] p;
    e.res = '0; e.hi = '0; e.ovf = 1'b0; e.dbz = 1'b0; e.lat = 1; e.acc = 0;
    sa     = longint'($signed(a));
    sbv    = longint'($signed(b));
    lim_hi = (longint'(1) <<< 31) - 1;
    lim_lo = -(longint'(1) <<< 31);
    case (op)
      OP_AND:  e.res = a & b;
      OP_OR:   e.res = a | b;
      OP_NOR:  e.res = ~(a | b);
      OP_SLTU: e.res = (a < b) ? 32'd1 : 32'd0;
      OP_ADD:  begin e.res = a + b; r = sa + sbv; e.ovf = (r > lim_hi) || (r < lim_lo); end
      OP_SUB:  begin e.res = a - b; r = sa - sbv; e.ovf = (r > lim_hi) || (r < lim_lo); end
      OP_MUL:  begin p = {32'd0, a} * {32'd0, b}; e.res = p[31:0]; e.hi = p[63:32]; e.lat = 33; end
      default: begin
`ifdef SEQ_ALU_DIVIDER_EN
        e.lat = 33;
        if (b == 32'd0) begin e.res = 32'hFFFF_FFFF; e.hi = a; e.dbz = 1'b1; end
        else begin e.res = a / b; e.hi = a % b; end
`else
        e.res = '0;
`endif
      end
    endcase
    e.zero = (e.res == 32'd0);
    return e;
  endfunction

  // Call only at posedge+1 so an already-ready DUT is not accepted unseen.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    bit   ok;
    ok = 1'b0;
    e = model(op, a, b);
    ALU_Control = op; scrA = a; scrB = b; in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    if (ok) begin e.acc = cyc; sb_q.push_back(e); end
    else chk("accept_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && sb_q.size() != 0; i++) @(negedge clk);
    chk("drain_left", 64'(sb_q.size()), 64'd0);
    sb_q.delete();
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (!out_valid) begin
      seen = 1'b0;
    end else begin
      if (!seen) begin
        seen = 1'b1; first_cyc = cyc; snap_res = ALU_RESULT; snap_hi = ALU_RESULT_HI;
      end else begin
        chk("hold_res", 64'(ALU_RESULT), 64'(snap_res));
        chk("hold_hi", 64'(ALU_RESULT_HI), 64'(snap_hi));
      end
      if (out_ready) begin
        seen = 1'b0;
        if (sb_q.size() == 0) begin
          chk("unexpected_valid", 64'd1, 64'd0);
        end else begin
          mon_e = sb_q.pop_front();
          chk("res", 64'(ALU_RESULT), 64'(mon_e.res));
          chk("hi", 64'(ALU_RESULT_HI), 64'(mon_e.hi));
          chk("zero", 64'(zero_flag), 64'(mon_e.zero));
          chk("ovf", 64'(ovf_flag), 64'(mon_e.ovf));
          chk("dbz", 64'(dbz_flag), 64'(mon_e.dbz));
          chk("latency", 64'(first_cyc - mon_e.acc), 64'(mon_e.lat));
        end
      end
    end
  end

  task automatic w8_run(input string tag, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] er, input logic [7:0] eh, input logic ez, input int elat);
    int acc;
    bit got;
    got = 1'b0;
    @(posedge clk); #1;
    w8_ctl = op; w8_a = a; w8_b = b; w8_in_valid = 1'b1;
    @(negedge clk);
    chk({tag, "_in_ready"}, 64'(w8_in_ready), 64'd1);
    acc = cyc;
    @(posedge clk); #1;
    w8_in_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (w8_out_valid) begin got = 1'b1; break; end
    end
    chk({tag, "_lat"}, 64'(got ? (cyc - acc) : 9999), 64'(elat));
    chk({tag, "_res"}, 64'(w8_res), 64'(er));
    chk({tag, "_hi"}, 64'(w8_hi), 64'(eh));
    chk({tag, "_zero"}, 64'(w8_zero), 64'(ez));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [2:0] rops [4];
    rops[0] = OP_ADD; rops[1] = OP_SUB; rops[2] = OP_MUL; rops[3] = OP_SLTU;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; scrA = '0; scrB = '0; ALU_Control = '0;
    w8_in_valid = 1'b0; w8_out_ready = 1'b1; w8_a = '0; w8_b = '0; w8_ctl = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_res", 64'(ALU_RESULT), 64'd0);
    chk("rst_hi", 64'(ALU_RESULT_HI), 64'd0);
    chk("rst_flags", 64'({zero_flag, ovf_flag, dbz_flag}), 64'd0);
    chk("rst_w8_valid", 64'(w8_out_valid), 64'd0);
    rst = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;

    issue(OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001);
    issue(OP_SUB, 32'd5, 32'd5);
    issue(OP_SUB, 32'h8000_0000, 32'd1);
    issue(OP_OR, 32'h1234_0000, 32'h0000_5678);
    issue(OP_NOR, 32'h0F0F_0F0F, 32'hF0F0_F0F0);
    issue(OP_SLTU, 32'hFFFF_FFFF, 32'd1);
    drain();

    issue(OP_MUL, 32'hFFFF_FFFF, 32'h0000_0002);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      chk("mul_busy_in_ready", 64'(in_ready), 64'd0);
    end
    drain();

    issue(OP_DIVU, 32'd100, 32'd7);
    issue(OP_DIVU, 32'd9, 32'd0);
    issue(OP_DIVU, 32'd5, 32'd9);
    drain();

    for (int i = 0; i < 6; i++) issue(rops[i % 4], $urandom, $urandom);
    drain();

    out_ready = 1'b0;
    issue(OP_SLTU, 32'd3, 32'd4);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_res", 64'(ALU_RESULT), 64'd1);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    issue(OP_AND, 32'h0000_F0F0, 32'h0000_0FF0);
    drain();

    issue(OP_MUL, 32'd3, 32'd5);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    sb_q.delete();
    @(posedge clk);
    @(negedge clk);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_res", 64'(ALU_RESULT), 64'd0);
    chk("midrst_hi", 64'(ALU_RESULT_HI), 64'd0);
    chk("midrst_flags", 64'({zero_flag, ovf_flag, dbz_flag}), 64'd0);
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      chk("stale_valid", 64'(out_valid), 64'd0);
    end

    w8_run("w8_nor", OP_NOR, 8'h0F, 8'hF0, 8'h00, 8'h00, 1'b1, 1);
    w8_run("w8_mul", OP_MUL, 8'hFF, 8'hFF, 8'h01, 8'hFE, 1'b0, 9);
`ifdef SEQ_ALU_DIVIDER_EN
    w8_run("w8_divu", OP_DIVU, 8'd200, 8'd7, 8'd28, 8'd4, 1'b0, 9);
`else
    w8_run("w8_divu", OP_DIVU, 8'd200, 8'd7, 8'd0, 8'd0, 1'b1, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_seq_alu.md
Name: mips_seq_alu

Overview:
- Parametrised, handshaked successor to the MIPS datapath ALU.
- Keeps the existing 3-bit op encoding and the zero flag.
- Adds registered results, signed-overflow detection, an iterative full-width multiply with a HI word, and an optional iterative unsigned divide.
- Sits between the register-read stage and writeback; the controller stalls on in_ready.

Parameters:
- WIDTH, 32, operand/result width; legal values 8..64.
- CNT_W, $clog2(WIDTH)+1, iteration counter width; derived, do not override.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset, synchronous, active-high
- in_valid  input  1  operands/op valid
- in_ready  output  1  block can accept operation this cycle
- scrA  input  WIDTH  operand A
- scrB  input  WIDTH  operand B
- ALU_Control  input  3  op: 000 AND, 001 OR, 010 ADD, 011 DIVU, 100 SUB, 101 MUL, 110 SLTU, 111 NOR
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- ALU_RESULT  output  WIDTH  result (low word / quotient)
- ALU_RESULT_HI  output  WIDTH  MUL upper word / DIVU remainder; 0 for other ops
- zero_flag  output  1  ALU_RESULT == 0
- ovf_flag  output  1  signed overflow, ADD/SUB only
- dbz_flag  output  1  DIVU with scrB == 0

Behaviour:
- Clock and reset: one clock, clk; rst is synchronous, active-high.
- Reset: state=IDLE, in_ready=1, out_valid=0; ALU_RESULT, ALU_RESULT_HI and all flags = 0.
- An operation is accepted when in_valid && in_ready. Operands and op are latched on acceptance and may change afterwards.
- States:
  - IDLE, MUL_BUSY, DIV_BUSY, DONE.
  - in_ready = (state==IDLE) || (state==DONE && out_ready).
  - IDLE/DONE accepting a single-cycle op (AND, OR, ADD, SUB, SLTU, NOR) -> DONE, result registered. out_valid is asserted the cycle after acceptance (latency 1).
  - Accepting MUL -> MUL_BUSY with counter=0. One shift-add step per cycle, unsigned WIDTH x WIDTH -> 2*WIDTH. After WIDTH steps -> DONE. out_valid asserts WIDTH+1 cycles after acceptance.
  - Accepting DIVU -> DIV_BUSY. Restoring division, one quotient bit per cycle, WIDTH cycles. out_valid at WIDTH+1.
  - DONE: out_valid=1. Outputs are held stable until out_valid && out_ready. On that handshake with no new accept -> IDLE. With a simultaneous accept -> next op (back-to-back; single-cycle ops sustain 1 op/cycle).
  - out_valid && !out_ready: hold DONE, in_ready=0, outputs frozen.
- Arithmetic:
  - ADD/SUB wrap modulo 2^WIDTH.
  - ovf_flag = operand signs equal (ADD) / differ (SUB) and result sign differs from A.
  - SLTU returns 1 or 0 zero-extended to WIDTH, unsigned compare.
  - MUL: low word in ALU_RESULT, high word in ALU_RESULT_HI.
  - zero_flag is evaluated on ALU_RESULT only.
  - Flags and HI are registered with the result and valid only while out_valid.
- DIVU boundaries:
  - scrB==0: quotient = all ones, remainder = scrA, dbz_flag=1. Still takes WIDTH+1 cycles (no early exit).
  - scrA < scrB: quotient 0, remainder scrA.
- Reset mid-operation (BUSY or DONE) aborts the op. The next cycle matches the reset state and the in-flight result is never presented.
- Inputs are ignored while in_ready=0.

Optional Feature:
- Macro SEQ_ALU_DIVIDER_EN.
- Defined: DIVU implemented as above.
- Undefined: divider datapath and DIV_BUSY are removed. Op 011 is treated as a single-cycle op with ALU_RESULT=0, ALU_RESULT_HI=0, zero_flag=1, dbz_flag=0, latency 1.

Test Plan:
- Reset mid-MUL: accept MUL, assert rst on cycle 5 -> cycle after: out_valid=0, in_ready=1, all outputs 0; no stale result appears afterwards.
- ADD 0x7FFFFFFF + 0x00000001 with out_ready=1 -> one cycle later: out_valid=1, ALU_RESULT=0x80000000, ovf_flag=1, zero_flag=0. Then SUB 5-5 back-to-back -> result 0, zero_flag=1, ovf_flag=0.
- MUL 0xFFFFFFFF x 0x00000002 -> out_valid exactly 33 cycles after accept, ALU_RESULT=0xFFFFFFFE, ALU_RESULT_HI=0x00000001; in_ready=0 throughout the busy cycles.
- DIVU 100 / 7 -> quotient 14, remainder 2 at 33 cycles. DIVU 9 / 0 -> ALU_RESULT=0xFFFFFFFF, ALU_RESULT_HI=9, dbz_flag=1. Without SEQ_ALU_DIVIDER_EN: 9 / 0 -> result 0, zero_flag=1, latency 1.
- Backpressure: SLTU 3 vs 4 with out_ready=0 for 4 cycles -> ALU_RESULT=1 held stable, in_ready=0. Raise out_ready together with in_valid for AND 0xF0F0 & 0x0FF0 -> next cycle ALU_RESULT=0x00F0.
- WIDTH=8 instance: NOR 0x0F, 0xF0 -> 0x00, zero_flag=1. MUL 0xFF x 0xFF -> low 0x01, HI 0xFE, 9-cycle latency.
